// File: rtl/mix_columns_sequencer_if.sv
// Stream handshake bundle for the MixColumns sequencer: state in, transformed state out.
// MIX_SEQ_LAST_ROUND_BYPASS_EN adds the in_last_round sideband that travels with in_state.
interface mix_columns_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
    logic         in_last_round;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    // slave = the sequencer, master = round controller / consumer side
    modport slave (
`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
        input  in_last_round,
`endif
        input  in_valid,
        input  in_state,
        input  in_inverse,
        output in_ready,
        output out_valid,
        output out_state,
        input  out_ready
    );

    modport master (
`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
        output in_last_round,
`endif
        output in_valid,
        output in_state,
        output in_inverse,
        input  in_ready,
        input  out_valid,
        input  out_state,
        output out_ready
    );
endinterface

// File: rtl/mix_columns_sequencer.sv
// Feeds one shared combinational MixColumns column datapath four times per AES state.
// Optional MIX_SEQ_LAST_ROUND_BYPASS_EN: states flagged in_last_round skip the datapath.
module mix_columns_sequencer #(
    parameter logic [31:0] FWD_COEF = 32'h02030101,
    parameter logic [31:0] INV_COEF = 32'h0E0B0D09
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mix_columns_sequencer_if.slave      bus,
    output logic                        busy,
    output logic [7:0]                  col_a0,
    output logic [7:0]                  col_a1,
    output logic [7:0]                  col_a2,
    output logic [7:0]                  col_a3,
    output logic [7:0]                  col_c0,
    output logic [7:0]                  col_c1,
    output logic [7:0]                  col_c2,
    output logic [7:0]                  col_c3,
    input  logic [7:0]                  col_b0,
    input  logic [7:0]                  col_b1,
    input  logic [7:0]                  col_b2,
    input  logic [7:0]                  col_b3,
    output logic [1:0]                  col_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] state_q, state_d;
    logic [127:0] result_q, result_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [31:0]  col_a_q, col_a_d;
    logic [31:0]  col_c_q, col_c_d;
    logic         accept;
    logic         bypass;

    function automatic logic [31:0] column_of(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] r;
        case (c)
            2'd0:    r = s[127:96];
            2'd1:    r = s[95:64];
            2'd2:    r = s[63:32];
            default: r = s[31:0];
        endcase
        return r;
    endfunction

`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
    assign bypass = bus.in_last_round;
`else
    assign bypass = 1'b0;
`endif

    assign accept = (fsm_q == IDLE) && bus.in_valid && in_ready_q;

    always_comb begin
        fsm_d       = fsm_q;
        col_d       = col_q;
        state_d     = state_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        col_a_d     = col_a_q;
        col_c_d     = col_c_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    state_d    = bus.in_state;
                    col_d      = 2'd0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (bypass) begin
                        // datapath outputs are left untouched on a bypassed state
                        result_d    = bus.in_state;
                        out_valid_d = 1'b1;
                        fsm_d       = DONE;
                    end else begin
                        col_a_d = column_of(bus.in_state, 2'd0);
                        col_c_d = bus.in_inverse ? INV_COEF : FWD_COEF;
                        fsm_d   = RUN;
                    end
                end
            end
            RUN: begin
                case (col_q)
                    2'd0:    result_d[127:96] = {col_b0, col_b1, col_b2, col_b3};
                    2'd1:    result_d[95:64]  = {col_b0, col_b1, col_b2, col_b3};
                    2'd2:    result_d[63:32]  = {col_b0, col_b1, col_b2, col_b3};
                    default: result_d[31:0]   = {col_b0, col_b1, col_b2, col_b3};
                endcase
                // counter wraps to 0 on the same edge that leaves RUN
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    col_a_d = column_of(state_q, col_q + 2'd1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            col_q       <= 2'd0;
            state_q     <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            col_a_q     <= '0;
            col_c_q     <= FWD_COEF;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            state_q     <= state_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            col_a_q     <= col_a_d;
            col_c_q     <= col_c_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = result_q;
    assign busy          = busy_q;
    assign col_idx       = col_q;
    assign {col_a0, col_a1, col_a2, col_a3} = col_a_q;
    assign {col_c0, col_c1, col_c2, col_c3} = col_c_q;

endmodule

// File: tb/tb_mix_columns_sequencer.sv
// Directed bench for mix_columns_sequencer with a GF(2^8) reference column datapath.
// Bypass steps run only when MIX_SEQ_LAST_ROUND_BYPASS_EN is defined.
module tb_mix_columns_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] col_a0, col_a1, col_a2, col_a3;
    logic [7:0] col_c0, col_c1, col_c2, col_c3;
    logic [7:0] col_b0, col_b1, col_b2, col_b3;
    logic [1:0] col_idx;

    int checks = 0;
    int errors = 0;

    mix_columns_sequencer_if bus ();

    mix_columns_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .col_a0  (col_a0),
        .col_a1  (col_a1),
        .col_a2  (col_a2),
        .col_a3  (col_a3),
        .col_c0  (col_c0),
        .col_c1  (col_c1),
        .col_c2  (col_c2),
        .col_c3  (col_c3),
        .col_b0  (col_b0),
        .col_b1  (col_b1),
        .col_b2  (col_b2),
        .col_b3  (col_b3),
        .col_idx (col_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // b_i = XOR_j c[(j-i) mod 4] * a_j
    function automatic logic [31:0] mix_model(input logic [31:0] a, input logic [31:0] c);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gmul(a[31-8*j -: 8], c[31-8*((j-i) & 3) -: 8]);
            end
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    assign {col_b0, col_b1, col_b2, col_b3} =
        mix_model({col_a0, col_a1, col_a2, col_a3}, {col_c0, col_c1, col_c2, col_c3});

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one state and walk it through RUN; transfers out if out_ready is high.
    task automatic process(input logic [127:0] s, input logic inv, input logic [127:0] exp,
                           input string tag);
        logic [31:0] coef;
        logic [31:0] col_exp;
        coef = inv ? 32'h0E0B0D09 : 32'h02030101;
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        bus.in_state   = s;
        bus.in_inverse = inv;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            col_exp = s[127-32*k -: 32];
            check($sformatf("%s.col_idx%0d", tag, k), col_idx, k[1:0]);
            check($sformatf("%s.col_c%0d", tag, k), {col_c0, col_c1, col_c2, col_c3}, coef);
            check($sformatf("%s.col_a%0d", tag, k), {col_a0, col_a1, col_a2, col_a3}, col_exp);
            check($sformatf("%s.busy%0d", tag, k), {busy, bus.in_ready, bus.out_valid}, 3'b100);
            if (k < 3) step();
        end
        step();
        check({tag, ".out_valid_e4"}, bus.out_valid, 1'b1);
        check({tag, ".out_state"}, bus.out_state, exp);
        check({tag, ".col_idx_done"}, col_idx, 2'd0);
        if (bus.out_ready) begin
            step();
            check({tag, ".after_xfer"}, {bus.out_valid, bus.in_ready, busy}, 3'b010);
        end
    endtask

    localparam logic [127:0] PLAIN = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] MIXED = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_state   = '0;
        bus.in_inverse = 1'b0;
        bus.out_ready  = 1'b1;
`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
        bus.in_last_round = 1'b0;
`endif
        step();
        step();
        check("rst.in_ready", bus.in_ready, 1'b1);
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.out_state", bus.out_state, 128'h0);
        check("rst.col_c", {col_c0, col_c1, col_c2, col_c3}, 32'h02030101);
        check("rst.col_a", {col_a0, col_a1, col_a2, col_a3}, 32'h0);
        check("rst.col_idx", col_idx, 2'd0);
        rst_n = 1'b1;
        step();

        process(PLAIN, 1'b0, MIXED, "fwd");
        process(MIXED, 1'b1, PLAIN, "inv");

        // backpressure: result held, second request ignored while in DONE
        bus.out_ready = 1'b0;
        process(PLAIN, 1'b0, MIXED, "bp");
        bus.in_state = MIXED;
        bus.in_inverse = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp.hold_state%0d", i), bus.out_state, MIXED);
            check($sformatf("bp.hold_flags%0d", i), {bus.out_valid, bus.in_ready, busy}, 3'b101);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp.xfer", {bus.out_valid, bus.in_ready, busy}, 3'b010);
        step();
        check("bp.single_xfer", {bus.out_valid, busy}, 2'b00);

        // reset while column 2 is being issued
        bus.in_state = PLAIN;
        bus.in_inverse = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("mid.col_idx", col_idx, 2'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid.idle", {bus.in_ready, busy, bus.out_valid}, 3'b100);
        check("mid.col_idx0", col_idx, 2'd0);
        check("mid.out_state", bus.out_state, 128'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("mid.no_out%0d", i), bus.out_valid, 1'b0);
        end
        process(PLAIN, 1'b0, MIXED, "post_rst");

`ifdef MIX_SEQ_LAST_ROUND_BYPASS_EN
        bus.in_state      = 128'h00112233_44556677_8899aabb_ccddeeff;
        bus.in_inverse    = 1'b0;
        bus.in_last_round = 1'b1;
        bus.in_valid      = 1'b1;
        step();
        bus.in_valid      = 1'b0;
        bus.in_last_round = 1'b0;
        check("byp.out_valid", bus.out_valid, 1'b1);
        check("byp.out_state", bus.out_state, 128'h00112233_44556677_8899aabb_ccddeeff);
        check("byp.col_idx", col_idx, 2'd0);
        check("byp.col_a_held", {col_a0, col_a1, col_a2, col_a3}, 32'h2d26314c);
        step();
        check("byp.xfer", {bus.out_valid, bus.in_ready}, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_sequencer.md
Name: mix_columns_sequencer

Overview:
- Controller that sequences one shared MixColumns datapath (combinational, one 32-bit column per evaluation) across a full 128-bit AES state.
- Accepts a state over a valid/ready handshake and sets the coefficient bytes for forward or inverse mode.
- Issues columns 0..3 on consecutive cycles, collects the results, and returns the transformed state over a second valid/ready handshake.
- Sits between the round controller and the mix-column datapath; it is the only driver of the datapath inputs.

Parameters:
- FWD_COEF, 32'h02030101, forward coefficients {c0,c1,c2,c3}.
- INV_COEF, 32'h0E0B0D09, inverse coefficients {c0,c1,c2,c3}.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_state/in_inverse valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3, row 0 first.
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_state valid.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  128  transformed state, same byte order as in_state.
- busy  output  1  high in RUN or DONE.
- col_a0..col_a3  output  8 each  column bytes to the datapath (a0 = row 0).
- col_c0..col_c3  output  8 each  coefficient bytes to the datapath.
- col_b0..col_b3  input  8 each  datapath result bytes, combinational from a/c.
- col_idx  output  2  column currently issued (debug/trace).

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; col counter=0; in_ready=1 after reset; out_valid=0, busy=0, out_state=0, col_a*=0, col_c*=FWD_COEF bytes, col_idx=0; the latched state and the result buffer are cleared.
- A reset that arrives mid-operation drops the in-flight state silently. No output handshake occurs.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready, latch in_state and in_inverse, col=0, go to RUN.
  - RUN: in_ready=0, busy=1.
    - col_a0..a3 = latched column col.
    - col_c* = INV_COEF if the latched inverse flag is set, else FWD_COEF.
    - col_idx = col.
    - Each edge stores col_b0..b3 into result column col and increments col.
    - At col==3 the edge goes to DONE.
  - DONE: out_valid=1, out_state=result buffer, held stable until out_ready.
    - On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle.
- Outputs col_a*/col_c* are registered-state driven (mux of latched state by col). They hold the last column value outside RUN.
- Latency:
  - Acceptance edge = E0; columns are captured at E1..E4.
  - out_valid is high from E4 onward.
  - Minimum initiation interval is 6 cycles with out_ready tied high.
- Backpressure: out_ready low holds DONE indefinitely. in_ready stays 0 and no new state is accepted.
- in_valid while not in IDLE is ignored; the source must hold it.
- The block only moves bytes; it does no arithmetic. The datapath result is assumed valid in the same cycle its inputs are driven.
- Counter: 2-bit. The wrap from 3 to 0 coincides with the RUN-to-DONE transition and is never visible as a fifth column.

Optional Feature:
- Macro MIX_SEQ_LAST_ROUND_BYPASS_EN.
- When defined:
  - Adds input in_last_round (1 bit), sampled with in_state.
  - If it is 1 at acceptance, go directly IDLE to DONE with out_state = in_state unchanged. out_valid is high the cycle after acceptance.
  - The datapath is not driven: col_a* hold their previous values and col_idx stays 0.
- When undefined: the port does not exist and every accepted state goes through RUN.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release. Expect in_ready=1, out_valid=0, busy=0, out_state=0, col_c = 02 03 01 01.
2. Forward mode, reference-model datapath, in_state = db135345_f20a225c_01010101_2d26314c, in_inverse=0. Expect out_state = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid at E4, col_idx sequence 0,1,2,3.
3. Inverse mode, in_state = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inverse=1. Expect out_state = db135345_f20a225c_01010101_2d26314c and col_c = 0e 0b 0d 09 throughout RUN.
4. Backpressure: out_ready=0 for 10 cycles after out_valid. Expect out_state stable, in_ready=0, and a second in_valid not accepted. Raise out_ready: one transfer occurs, then in_ready=1 the next cycle.
5. Reset mid-RUN: assert rst_n=0 at col_idx=2. Expect IDLE next cycle, out_valid never asserted, next state processed correctly.
6. With MIX_SEQ_LAST_ROUND_BYPASS_EN defined, in_last_round=1, in_state = 00112233_44556677_8899aabb_ccddeeff. Expect out_state identical, out_valid one cycle after acceptance, col_idx stays 0.
